// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - instruction memory with fetch handshake, load port and boot-clear
module instr_mem_ctrl #(
    parameter int              DATA_W         = 16,
    parameter int              DEPTH          = 16,
    parameter int              PC_W           = 4,
    parameter logic [DATA_W-1:0] NOP_WORD     = '0,
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [PC_W-1:0]   instr_pc,
    output logic              instr_err,
    input  logic              instr_ack,
    input  logic              flush,
    input  logic              load_en,
    input  logic [PC_W-1:0]   load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err,
    output logic              busy
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PC_W:0]   DEPTH_X   = (PC_W+1)'(DEPTH);
    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [PC_W-1:0]     clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                fetch_in_range;
    logic                load_in_range;
    logic                accept;
    logic                load_we;
    logic                load_hit;
    logic [DATA_W-1:0]   rd_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_CLEAR: if (clr_cnt == LAST_ADDR) state_n = ST_RUN;
            ST_RUN:   state_n = ST_RUN;
            default:  state_n = ST_RUN;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        fetch_ready = 1'b0;
        case (state)
            ST_CLEAR: busy = 1'b1;
            ST_RUN:   fetch_ready = !instr_valid || instr_ack;
            default:  fetch_ready = 1'b0;
        endcase
    end

    // Counter parks at the last address once the sweep is done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR && clr_cnt != LAST_ADDR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign fetch_in_range = {1'b0, fetch_pc}  < DEPTH_X;
    assign load_in_range  = {1'b0, load_addr} < DEPTH_X;
    assign accept         = fetch_req && fetch_ready && !flush;
    assign load_we        = (state == ST_RUN) && load_en && load_in_range;
    assign load_hit       = load_we && (load_addr == fetch_pc);

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt[AW-1:0]] <= NOP_WORD;
        end else if (load_we) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    // Same-cycle load to the fetched address bypasses the array.
    always_comb begin
        rd_word = NOP_WORD;
        if (fetch_in_range) begin
            rd_word = load_hit ? load_data : mem[fetch_pc[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_valid  <= 1'b0;
            instr_opcode <= NOP_WORD;
            instr_pc     <= '0;
            instr_err    <= 1'b0;
        end else if (flush) begin
            instr_valid  <= 1'b0;
        end else if (accept) begin
            instr_valid  <= 1'b1;
            instr_opcode <= rd_word;
            instr_pc     <= fetch_pc;
            instr_err    <= !fetch_in_range;
        end else if (instr_ack) begin
            instr_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_err <= 1'b0;
        end else if (state == ST_RUN && load_en && !load_in_range) begin
            load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - directed vector bench for instr_mem_ctrl (DEPTH 16 and 12)
module tb_instr_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [3:0]  fetch_pc;
    logic        instr_ack;
    logic        flush;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;

    logic        a_ready, a_valid, a_err, a_lerr, a_busy;
    logic [15:0] a_op;
    logic [3:0]  a_pc;
    logic        b_ready, b_valid, b_err, b_lerr, b_busy;
    logic [15:0] b_op;
    logic [3:0]  b_pc;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_mem_ctrl #(.DATA_W(16), .DEPTH(16), .PC_W(4), .NOP_WORD(16'h0000), .CLEAR_ON_RESET(1'b1)) dut16 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_ready(a_ready), .instr_valid(a_valid), .instr_opcode(a_op), .instr_pc(a_pc),
        .instr_err(a_err), .instr_ack(instr_ack), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .load_err(a_lerr), .busy(a_busy)
    );

    instr_mem_ctrl #(.DATA_W(16), .DEPTH(12), .PC_W(4), .NOP_WORD(16'h0000), .CLEAR_ON_RESET(1'b1)) dut12 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_ready(b_ready), .instr_valid(b_valid), .instr_opcode(b_op), .instr_pc(b_pc),
        .instr_err(b_err), .instr_ack(instr_ack), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .load_err(b_lerr), .busy(b_busy)
    );

    typedef struct {
        logic        req;
        logic [3:0]  pc;
        logic        ack;
        logic        fl;
        logic        ld;
        logic [3:0]  la;
        logic [15:0] ldd;
        logic        e_rdy;
        logic        e_val;
        logic        chk_d;
        logic [15:0] e_op;
        logic [3:0]  e_pc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic req, logic [3:0] pc, logic ack, logic fl, logic ld,
                                logic [3:0] la, logic [15:0] ldd, logic e_rdy, logic e_val,
                                logic chk_d, logic [15:0] e_op, logic [3:0] e_pc);
        vec_t v;
        v.req = req; v.pc = pc; v.ack = ack; v.fl = fl; v.ld = ld; v.la = la; v.ldd = ldd;
        v.e_rdy = e_rdy; v.e_val = e_val; v.chk_d = chk_d; v.e_op = e_op; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [3:0] pc, input logic ack, input logic fl,
                         input logic ld, input logic [3:0] la, input logic [15:0] ldd);
        fetch_req = req; fetch_pc = pc; instr_ack = ack; flush = fl;
        load_en = ld; load_addr = la; load_data = ldd;
    endtask

    task automatic count_clear(input string nm, input int exp16, input int exp12);
        int c16 = 0;
        int c12 = 0;
        int rdy_bad = 0;
        for (int k = 0; k < 24; k++) begin
            #1;
            if (a_busy) c16++;
            if (b_busy) c12++;
            if (a_busy && a_ready) rdy_bad++;
            @(negedge clk);
        end
        chk({nm, "_busy16"}, c16, exp16);
        chk({nm, "_busy12"}, c12, exp12);
        chk({nm, "_ready_in_clear"}, rdy_bad, 0);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 16'h0);

        for (int i = 0; i < 16; i++)
            vq.push_back(mk(1, 4'(i), 1, 0, 0, 0, 16'h0, 1, 1, 1, 16'h0000, 4'(i)));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0,    1, 0, 0, 16'h0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 16'h1234, 1, 0, 0, 16'h0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 16'h2452, 1, 0, 0, 16'h0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 3, 16'h4891, 1, 0, 0, 16'h0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 4, 16'h7777, 1, 0, 0, 16'h0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 5, 16'h5ABA, 1, 0, 0, 16'h0, 0));
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 16'h0,    1, 1, 1, 16'h1234, 0));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 16'h0,    1, 1, 1, 16'h2452, 1));
        vq.push_back(mk(1, 3, 1, 0, 0, 0, 16'h0,    1, 1, 1, 16'h4891, 3));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 4, 0, 0, 0, 0, 16'h0, 0, 1, 1, 16'h4891, 3));
        vq.push_back(mk(1, 4, 1, 0, 0, 0, 16'h0,    1, 1, 1, 16'h7777, 4));
        vq.push_back(mk(1, 5, 1, 0, 1, 5, 16'hABCD, 1, 1, 1, 16'hABCD, 5));
        vq.push_back(mk(1, 5, 1, 0, 0, 0, 16'h0,    1, 1, 1, 16'hABCD, 5));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0,    0, 1, 1, 16'hABCD, 5));
        vq.push_back(mk(1, 0, 1, 1, 0, 0, 16'h0,    1, 0, 0, 16'h0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0,    1, 0, 0, 16'h0, 0));
        vq.push_back(mk(1, 7, 0, 1, 1, 6, 16'h6666, 1, 0, 0, 16'h0, 0));
        vq.push_back(mk(1, 6, 1, 0, 0, 0, 16'h0,    1, 1, 1, 16'h6666, 6));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0,    1, 0, 0, 16'h0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  a_valid, 0);
        chk("rst_opcode", a_op, 16'h0000);
        chk("rst_pc",     a_pc, 0);
        chk("rst_err",    a_err, 0);
        chk("rst_lerr",   a_lerr, 0);
        chk("rst_busy",   a_busy, 1);
        chk("rst_ready",  a_ready, 0);

        @(negedge clk);
        reset = 1'b1;
        count_clear("boot", 16, 12);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].req, vq[i].pc, vq[i].ack, vq[i].fl, vq[i].ld, vq[i].la, vq[i].ldd);
            #1;
            chk($sformatf("v%0d_ready", i), a_ready, vq[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), a_valid, vq[i].e_val);
            if (vq[i].chk_d) begin
                chk($sformatf("v%0d_opcode", i), a_op, vq[i].e_op);
                chk($sformatf("v%0d_pc", i), a_pc, vq[i].e_pc);
                chk($sformatf("v%0d_err", i), a_err, 0);
            end
        end
        chk("lerr12_clean", b_lerr, 0);

        @(negedge clk);
        drive(0, 0, 0, 0, 1, 14, 16'hBEEF);
        @(posedge clk); #1;
        chk("lerr12_set", b_lerr, 1);
        chk("lerr16_clear", a_lerr, 0);

        @(negedge clk);
        drive(1, 13, 1, 0, 0, 0, 16'h0);
        @(posedge clk); #1;
        chk("oor_valid",  b_valid, 1);
        chk("oor_opcode", b_op, 16'h0000);
        chk("oor_err",    b_err, 1);
        chk("oor_pc",     b_pc, 13);

        @(negedge clk);
        drive(1, 14, 1, 0, 0, 0, 16'h0);
        @(posedge clk); #1;
        chk("d16_pc14_opcode", a_op, 16'hBEEF);
        chk("d16_pc14_err",    a_err, 0);
        chk("d12_pc14_err",    b_err, 1);
        chk("d12_pc14_opcode", b_op, 16'h0000);

        @(negedge clk);
        drive(1, 2, 1, 0, 0, 0, 16'h0);
        @(posedge clk); #1;
        chk("d12_pc2_opcode", b_op, 16'h0000);
        chk("d12_pc2_err",    b_err, 0);
        chk("lerr12_sticky",  b_lerr, 1);

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(negedge clk);
        chk("mid_busy", a_busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_lerr12", b_lerr, 0);
        chk("mid_rst_valid",  a_valid, 0);
        reset = 1'b1;
        count_clear("reclear", 16, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
